// File: rtl/qpsk_symbol_scheduler_if.sv
// Bit-stream input and LUT-address output bundle of the QPSK symbol scheduler.
interface qpsk_symbol_scheduler_if #(
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              bit_in;
  logic              bit_valid;
  logic              bit_ready;
  logic              enable;
  logic [ADDR_W-1:0] lut_addr;
  logic              sample_valid;
  logic              sym_start;
  logic [1:0]        sym_dibit;
  logic              underrun;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output bit_in, bit_valid, enable,
    input  bit_ready, lut_addr, sample_valid, sym_start, sym_dibit, underrun, fifo_level
  );

  modport slave (
    input  bit_in, bit_valid, enable,
    output bit_ready, lut_addr, sample_valid, sym_start, sym_dibit, underrun, fifo_level
  );
endinterface

// File: rtl/qpsk_symbol_scheduler.sv
// Pairs serial bits into dibits, buffers them, and plays one sine-LUT period per dibit.
// Define QPSK_SCHED_GRAY_EN for Gray-coded phase mapping (natural binary otherwise).
module qpsk_symbol_scheduler #(
  parameter int SPS        = 100,
  parameter int ADDR_W     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  qpsk_symbol_scheduler_if.slave  s_if
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [LVL_W-1:0]  DEPTH_L = LVL_W'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(SPS - 1);
  localparam logic [ADDR_W-1:0] OFF_Q1  = ADDR_W'(SPS / 4);
  localparam logic [ADDR_W-1:0] OFF_Q2  = ADDR_W'(SPS / 2);
  localparam logic [ADDR_W-1:0] OFF_Q3  = ADDR_W'((3 * SPS) / 4);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  function automatic logic [ADDR_W-1:0] phase_off(input logic [1:0] dibit);
    logic [1:0] quad;
`ifdef QPSK_SCHED_GRAY_EN
    quad = {dibit[1], dibit[1] ^ dibit[0]};
`else
    quad = dibit;
`endif
    case (quad)
      2'b00:   phase_off = '0;
      2'b01:   phase_off = OFF_Q1;
      2'b10:   phase_off = OFF_Q2;
      default: phase_off = OFF_Q3;
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] cnt);
    logic [ADDR_W:0] sum;
    sum = {1'b0, base} + {1'b0, cnt};
    if (sum >= (ADDR_W+1)'(SPS)) sum = sum - (ADDR_W+1)'(SPS);
    wrap_addr = sum[ADDR_W-1:0];
  endfunction

  logic [1:0]        r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_pend, r_d_bit;
  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt, r_base, r_lut_addr;
  logic [1:0]        r_cur_dibit, r_sym_dibit;
  logic              r_sample_valid, r_sym_start, r_underrun;

  logic              w_ready, w_xfer, w_push, w_pop;
  logic [1:0]        w_head;

  assign w_ready = !i_rst && (r_level < DEPTH_L);
  assign w_xfer  = s_if.bit_valid && w_ready;
  assign w_push  = w_xfer && r_pend;
  assign w_head  = r_mem[r_rd_ptr];
  // A pop happens only where a symbol may start: from IDLE or on the last sample.
  assign w_pop   = !i_rst && s_if.enable && (r_level != '0) &&
                   ((r_state == ST_IDLE) || (r_cnt == LAST));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend <= 1'b0;
    end else if (w_xfer) begin
      r_pend <= !r_pend;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_xfer && !r_pend) r_d_bit <= s_if.bit_in;
    if (w_push) r_mem[r_wr_ptr] <= {r_d_bit, s_if.bit_in};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= '0;
      r_base         <= '0;
      r_cur_dibit    <= '0;
      r_lut_addr     <= '0;
      r_sample_valid <= 1'b0;
      r_sym_start    <= 1'b0;
      r_sym_dibit    <= '0;
      r_underrun     <= 1'b0;
    end else begin
      r_sym_start <= 1'b0;
      r_underrun  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_sample_valid <= 1'b0;
          if (w_pop) begin
            r_base      <= phase_off(w_head);
            r_cur_dibit <= w_head;
            r_cnt       <= '0;
            r_state     <= ST_RUN;
          end
        end
        default: begin
          r_lut_addr     <= wrap_addr(r_base, r_cnt);
          r_sample_valid <= 1'b1;
          r_sym_start    <= (r_cnt == '0);
          r_sym_dibit    <= r_cur_dibit;
          // Last sample of the symbol: chain the next one seamlessly or fall back to IDLE.
          if (r_cnt == LAST) begin
            if (w_pop) begin
              r_base      <= phase_off(w_head);
              r_cur_dibit <= w_head;
              r_cnt       <= '0;
            end else begin
              r_state    <= ST_IDLE;
              r_underrun <= s_if.enable;
            end
          end else begin
            r_cnt <= r_cnt + ADDR_W'(1);
          end
        end
      endcase
    end
  end

  assign s_if.bit_ready    = w_ready;
  assign s_if.lut_addr     = r_lut_addr;
  assign s_if.sample_valid = r_sample_valid;
  assign s_if.sym_start    = r_sym_start;
  assign s_if.sym_dibit    = r_sym_dibit;
  assign s_if.underrun     = r_underrun;
  assign s_if.fifo_level   = r_level;
endmodule

// File: tb/tb_qpsk_symbol_scheduler.sv
// Directed bench for qpsk_symbol_scheduler (SPS=100, ADDR_W=7, FIFO_DEPTH=4).
module tb_qpsk_symbol_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  qpsk_symbol_scheduler_if #(.ADDR_W(7), .FIFO_DEPTH(4)) bus ();

  qpsk_symbol_scheduler #(.SPS(100), .ADDR_W(7), .FIFO_DEPTH(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .s_if  (bus.slave)
  );

  function automatic int exp_off(input logic [1:0] d);
`ifdef QPSK_SCHED_GRAY_EN
    case (d)
      2'b00:   exp_off = 0;
      2'b01:   exp_off = 25;
      2'b11:   exp_off = 50;
      default: exp_off = 75;
    endcase
`else
    case (d)
      2'b00:   exp_off = 0;
      2'b01:   exp_off = 25;
      2'b10:   exp_off = 50;
      default: exp_off = 75;
    endcase
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    while (!acc && guard < 500) begin
      acc = bus.bit_ready;
      tick();
      guard++;
    end
    bus.bit_valid = 1'b0;
    if (!acc) chk("send_bit_timeout", 32'd0, 32'd1);
  endtask

  task automatic play_symbol(input logic [1:0] d, input logic exp_und, input int drop_at);
    int off;
    off = exp_off(d);
    for (int i = 0; i < 100; i++) begin
      tick();
      if (i == 0) bus.bit_valid = 1'b0;
      chk("sample_valid", 32'(bus.sample_valid), 32'd1);
      chk("lut_addr", 32'(bus.lut_addr), 32'((off + i) % 100));
      chk("sym_start", 32'(bus.sym_start), 32'(i == 0));
      chk("sym_dibit", 32'(bus.sym_dibit), 32'(d));
      chk("underrun", 32'(bus.underrun), (i == 99) ? 32'(exp_und) : 32'd0);
      if (i == drop_at) bus.enable = 1'b0;
    end
  endtask

  task automatic check_idle(input string tag, input int lvl);
    chk({tag, "_sample_valid"}, 32'(bus.sample_valid), 32'd0);
    chk({tag, "_underrun"}, 32'(bus.underrun), 32'd0);
    chk({tag, "_fifo_level"}, 32'(bus.fifo_level), 32'(lvl));
  endtask

  initial begin
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.enable    = 1'b0;

    // 1: reset
    rst = 1'b1;
    #1;
    chk("rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    tick(); tick(); tick();
    chk("rst_bit_ready_held", 32'(bus.bit_ready), 32'd0);
    chk("rst_sample_valid", 32'(bus.sample_valid), 32'd0);
    chk("rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("rst_lut_addr", 32'(bus.lut_addr), 32'd0);
    chk("rst_sym_start", 32'(bus.sym_start), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_bit_ready", 32'(bus.bit_ready), 32'd1);

    // 2: single symbol 01, latency 2, then underrun
    bus.enable = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    chk("t2_level_after_push", 32'(bus.fifo_level), 32'd1);
    chk("t2_no_sample_yet", 32'(bus.sample_valid), 32'd0);
    tick();
    chk("t2_latency_1cyc", 32'(bus.sample_valid), 32'd0);
    play_symbol(2'b01, 1'b1, -1);
    tick();
    check_idle("t2_idle", 0);

    // 3: three buffered symbols play back-to-back
    bus.enable = 1'b0;
    send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    check_idle("t3_loaded", 3);
    bus.enable = 1'b1;
    tick();
    play_symbol(2'b00, 1'b0, -1);
    play_symbol(2'b11, 1'b0, -1);
    play_symbol(2'b10, 1'b1, -1);
    tick();
    check_idle("t3_idle", 0);

    // 4: full FIFO holds the 9th bit until space opens
    bus.enable = 1'b0;
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b0);
    chk("t4_full_level", 32'(bus.fifo_level), 32'd4);
    chk("t4_full_ready", 32'(bus.bit_ready), 32'd0);
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    tick(); tick();
    chk("t4_held_level", 32'(bus.fifo_level), 32'd4);
    chk("t4_held_ready", 32'(bus.bit_ready), 32'd0);
    bus.enable = 1'b1;
    tick();
    chk("t4_ready_after_pop", 32'(bus.bit_ready), 32'd1);
    play_symbol(2'b11, 1'b0, -1);
    play_symbol(2'b01, 1'b0, -1);
    play_symbol(2'b10, 1'b0, -1);
    play_symbol(2'b00, 1'b1, -1);
    tick();
    check_idle("t4_idle", 0);
    send_bit(1'b0);
    tick();
    play_symbol(2'b10, 1'b1, -1);
    tick();
    check_idle("t4_pair_idle", 0);

    // 5: enable drops mid-symbol; symbol completes, no underrun
    bus.enable = 1'b0;
    send_bit(1'b0); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1);
    bus.enable = 1'b1;
    tick();
    play_symbol(2'b01, 1'b0, 40);
    tick();
    check_idle("t5_idle", 1);
    tick(); tick();
    check_idle("t5_stays_idle", 1);

    // 6: reset mid-symbol clears FIFO and pending half-dibit
    send_bit(1'b0); send_bit(1'b0);
    chk("t6_level2", 32'(bus.fifo_level), 32'd2);
    bus.enable = 1'b1;
    tick();
    bus.bit_in    = 1'b1;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    chk("t6_first_addr", 32'(bus.lut_addr), 32'(exp_off(2'b11)));
    chk("t6_first_start", 32'(bus.sym_start), 32'd1);
    for (int k = 0; k < 60; k++) tick();
    chk("t6_cnt60_addr", 32'(bus.lut_addr), 32'((exp_off(2'b11) + 60) % 100));
    chk("t6_cnt60_level", 32'(bus.fifo_level), 32'd1);
    rst = 1'b1;
    tick();
    chk("t6_rst_sample_valid", 32'(bus.sample_valid), 32'd0);
    chk("t6_rst_fifo_level", 32'(bus.fifo_level), 32'd0);
    chk("t6_rst_lut_addr", 32'(bus.lut_addr), 32'd0);
    chk("t6_rst_bit_ready", 32'(bus.bit_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_post_rst_ready", 32'(bus.bit_ready), 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    tick();
    play_symbol(2'b10, 1'b1, -1);
    tick();
    check_idle("t6_idle", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
